// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// legal WIDTH range and the bit-counter width helper.
package serial_adder_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter must hold 0..WIDTH-1 and be at least one bit wide.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder, the arithmetic element shared across all bit positions
// by serial_adder_ctrl.
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);

    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first, one bit
// per clock, through a single full_adder with a registered carry.
// Input and output use valid/ready handshakes; one operation in flight.
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the 'sub' port, selecting
// a - b (B latched inverted, carry seeded with 1, cout=1 means no borrow).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
            $error("serial_adder_ctrl: WIDTH %0d outside legal range", WIDTH);
        end
    endgenerate

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_a_q, shift_a_d;
    logic [WIDTH-1:0]  shift_b_q, shift_b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]    sum_shift;
    logic              fa_sum;
    logic              fa_cout;
    logic              op_sub;

`ifdef SERIAL_ADDER_SUB_EN
    assign op_sub = sub;
`else
    assign op_sub = 1'b0;
`endif

    full_adder u_fa (
        .A    (shift_a_q[0]),
        .B    (shift_b_q[0]),
        .Cin  (carry_q),
        .Sum  (fa_sum),
        .Cout (fa_cout)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs, all derived from state only.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath next-state: operand capture in IDLE, one bit per RUN cycle.
    always_comb begin
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        carry_d   = carry_q;
        cnt_d     = cnt_q;
        // Prepending the new bit and dropping the LSB is a right shift that
        // still works when WIDTH is 1.
        sum_shift = {fa_sum, sum_q};
        if (state_q == ST_IDLE && in_valid) begin
            shift_a_d = a;
            shift_b_d = op_sub ? ~b : b;
            carry_d   = op_sub ? 1'b1 : cin;
            cnt_d     = '0;
        end else if (state_q == ST_RUN) begin
            shift_a_d = shift_a_q >> 1;
            shift_b_d = shift_b_q >> 1;
            sum_d     = sum_shift[WIDTH:1];
            carry_d   = fa_cout;
            cnt_d     = cnt_q + CW'(1);
            // cout is only updated on the final bit so it holds in IDLE even
            // though the carry register is reloaded on the next accept.
            if (cnt_q == CNT_LAST) begin
                cout_d = fa_cout;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            carry_q   <= carry_d;
            cnt_q     <= cnt_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8). Accepted operations push
// their expected {cout,sum} into a queue; a negedge monitor pops and compares
// on each output handshake, and checks latency, hold stability and in_ready.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int last_acc = -1;
    bit b2b_mode = 1'b0;

    logic [W:0] exp_q[$];
    int         acc_q[$];

    bit           prev_ov   = 1'b0;
    bit           prev_hold = 1'b0;
    logic [W-1:0] prev_sum;
    logic         prev_cout;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                         input logic ic, input logic is);
        longint unsigned r;
        logic [W:0] res;
        if (is) begin
            r = (longint'(ia) - longint'(ib)) & ((64'd1 << W) - 1);
            res = {(ia >= ib), r[W-1:0]};
        end else begin
            r = longint'(ia) + longint'(ib) + longint'(ic);
            res = r[W:0];
        end
        return res;
    endfunction

    // Monitor: observe both handshakes half a cycle before the edge that takes them.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov   = 1'b0;
            prev_hold = 1'b0;
        end else begin
            chk("in_ready_vs_busy", in_ready, !busy);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                acc_q.push_back(cyc + 1);
                if (b2b_mode && last_acc >= 0)
                    chk("b2b_accept_spacing", cyc + 1 - last_acc, W + 2);
                last_acc = cyc + 1;
                n_acc++;
            end
            if (prev_hold) begin
                chk("hold_out_valid", out_valid, 1);
                chk("hold_sum", sum, prev_sum);
                chk("hold_cout", cout, prev_cout);
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("unexpected_out_valid", 1, 0);
                else chk("latency_edges", cyc - acc_q.pop_front(), W);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("result_without_op", 1, 0);
                else chk("result_cout_sum", {cout, sum}, exp_q.pop_front());
            end
            prev_ov   = out_valid;
            prev_hold = out_valid && !out_ready;
            prev_sum  = sum;
            prev_cout = cout;
        end
    end

    // Present operands and hold in_valid until the monitor records an accept.
    task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic ic, input logic is, input bit keep);
        int start;
        bit got;
        start = n_acc;
        got = 1'b0;
        a = ia; b = ib; cin = ic; sub = is;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            @(posedge clk); #1;
            if (n_acc != start) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 0, 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd_ready);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(posedge clk); #1;
            if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() == 0 && !busy) done = 1'b1;
        end
        if (!done) chk("drain_timeout", 0, 1);
        out_ready = 1'b1;
    endtask

    task automatic rand_sub(output logic s);
`ifdef SERIAL_ADDER_SUB_EN
        s = 1'($urandom_range(0, 1));
`else
        s = 1'b0;
`endif
    endtask

    initial begin
        int acc0;
        logic s;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        #3;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        chk("reset_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("in_ready_after_reset", in_ready, 1);

        // Directed additions, including carry-out corner cases.
        send(8'h5A, 8'h3C, 1'b0, 1'b0, 0); wait_idle(0);
        chk("hold_sum_in_idle", sum, 8'h96);
        send(8'hFF, 8'h01, 1'b0, 1'b0, 0); wait_idle(0);
        chk("hold_cout_in_idle", cout, 1);
        send(8'hFF, 8'hFF, 1'b1, 1'b0, 0); wait_idle(0);
        send(8'h00, 8'h00, 1'b0, 1'b0, 0); wait_idle(0);

        // Backpressure: result held, in_valid pulses ignored.
        out_ready = 1'b0;
        send(8'h12, 8'h34, 1'b1, 1'b0, 0);
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_out_valid_seen", out_valid, 1);
        acc0 = n_acc;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            in_valid = (i % 2 == 0); a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        chk("bp_no_extra_accept", n_acc, acc0);
        chk("bp_still_valid", out_valid, 1);
        out_ready = 1'b1;
        wait_idle(0);

        // Reset in the middle of RUN, then a clean operation.
        send(8'hC3, 8'h5E, 1'b1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_sum", sum, 0);
        chk("midreset_cout", cout, 0);
        chk("midreset_busy", busy, 0);
        exp_q.delete(); acc_q.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        send(8'h01, 8'h02, 1'b0, 1'b0, 0); wait_idle(0);
        chk("post_reset_sum", sum, 8'h03);
        chk("post_reset_cout", cout, 0);

        // Back-to-back with in_valid and out_ready held high.
        b2b_mode = 1'b1; last_acc = -1;
        for (int i = 0; i < 3; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, i < 2);
        wait_idle(0);
        b2b_mode = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
        send(8'h10, 8'h01, 1'b0, 1'b1, 0); wait_idle(0);
        chk("sub_sum", sum, 8'h0F);
        chk("sub_cout", cout, 1);
        send(8'h01, 8'h02, 1'b1, 1'b1, 0); wait_idle(0);
        chk("sub_borrow_sum", sum, 8'hFF);
        chk("sub_borrow_cout", cout, 0);
`endif

        // Randomized operations with a randomly stalling consumer.
        for (int i = 0; i < 30; i++) begin
            rand_sub(s);
            out_ready = 1'($urandom_range(0, 1));
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), s, 0);
            wait_idle(1);
        end

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
